// File: rtl/uart_core.sv
// uart_core: parametrised UART transceiver. Compile-time frame format
// (5-8 data bits, none/odd/even parity, 1 or 2 stop bits), 16x oversampled
// receiver with start-bit glitch filter, and an independent transmitter.
//
// Handshakes (both directions): a transfer happens on a rising edge where
// valid and ready are both high. tx_valid may be raised at any time; tx_ready
// is high only while the transmitter is idle. rx_valid stays high with
// rx_data/flags stable until the edge where rx_ready is also high.
module uart_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int TICK_DIV = CLK_HZ / (BAUD * 16);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BIT_CLKS = 16 * TICK_DIV;
    localparam int BIT_W    = $clog2(BIT_CLKS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BIT_CLKS - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    // Reject unusable configurations at elaboration time.
    if (TICK_DIV < 1) begin : g_bad_div
        $error("uart_core: CLK_HZ too low for BAUD (TICK_DIV < 1)");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("uart_core: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_core: STOP_BITS must be 1 or 2");
    end

    // ------------------------------------------------------------------
    // 16x tick generator (RX only; TX has its own bit timer)
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    // Free-running divider; tick marks the wrap.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Tick counter register.
    always_ff @(posedge clk) begin
        if (reset) tick_cnt_q <= '0;
        else       tick_cnt_q <= tick_cnt_d;
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    tx_state_e              tx_state_q, tx_state_d;
    logic [BIT_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic [2:0]             tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_q, tx_d;

    // TX next state: the bit timer restarts at accept, so each line bit is
    // exactly BIT_CLKS clocks long regardless of the RX tick phase.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        if (tx_state_q == TX_IDLE) begin
            tx_d = 1'b1;
            if (tx_valid) begin
                tx_shift_d = tx_data;
                tx_par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
                tx_cnt_d   = '0;
                tx_state_d = TX_START;
                tx_d       = 1'b0;
            end
        end else if (tx_cnt_q != BIT_LAST) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end else begin
            tx_cnt_d = '0;
            case (tx_state_q)
                TX_START: begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
                TX_DATA: begin
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d = '0;
                        if (PARITY != 0) begin
                            tx_state_d = TX_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
                TX_PARITY: begin
                    tx_state_d = TX_STOP;
                    tx_bit_d   = '0;
                    tx_d       = 1'b1;
                end
                TX_STOP: begin
                    tx_d = 1'b1;
                    if (tx_bit_q == STOP_LAST) tx_state_d = TX_IDLE;
                    else                       tx_bit_d   = tx_bit_q + 3'd1;
                end
                default: begin
                    tx_state_d = TX_IDLE;
                    tx_d       = 1'b1;
                end
            endcase
        end
    end

    // TX registers; reset aborts any frame and drives the line idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_ready = (tx_state_q == TX_IDLE);
    assign tx       = tx_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;

    logic                 rx_s1_q, rx_s2_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_done;
    logic                 rx_stop_bad;
    logic                 rx_par_bad;

    logic                 rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_fe_q, rx_fe_d;
    logic                 rx_pe_q, rx_pe_d;
    logic                 rx_ovr_q, rx_ovr_d;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    // RX next state: half a bit into START re-checks the line (glitch
    // filter), then every 16 ticks samples mid-bit. Only the first stop bit
    // is checked so a following start edge is caught without delay.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_d    = rx_par_q;
        rx_done     = 1'b0;
        rx_stop_bad = 1'b0;
        if (tick) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_s2_q) begin
                        rx_state_d = RX_START;
                        rx_cnt_d   = '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == 4'd7) begin
                        rx_cnt_d = '0;
                        rx_bit_d = '0;
                        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
                RX_DATA: begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'd15) begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == DATA_LAST)
                            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                        else
                            rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
                RX_PARITY: begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'd15) begin
                        rx_par_d   = rx_s2_q;
                        rx_state_d = RX_STOP;
                    end
                end
                RX_STOP: begin
                    rx_cnt_d = rx_cnt_q + 4'd1;
                    if (rx_cnt_q == 4'd15) begin
                        rx_done     = 1'b1;
                        rx_stop_bad = !rx_s2_q;
                        rx_state_d  = RX_IDLE;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    // RX output holding register: an acknowledge frees the slot in the same
    // edge a new frame may load it; a frame arriving into a held slot is
    // dropped and marked by the sticky overrun flag.
    always_comb begin
        rx_par_bad = 1'b0;
        if (PARITY == 1)      rx_par_bad = ~(^rx_shift_q ^ rx_par_q);
        else if (PARITY == 2) rx_par_bad = ^rx_shift_q ^ rx_par_q;
        rx_valid_d = rx_valid_q & ~rx_ready;
        rx_data_d  = rx_data_q;
        rx_fe_d    = rx_fe_q;
        rx_pe_d    = rx_pe_q;
        rx_ovr_d   = rx_ovr_q;
        if (rx_done) begin
            if (rx_valid_d) begin
                rx_ovr_d = 1'b1;
            end else begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_shift_q;
                rx_fe_d    = rx_stop_bad;
                rx_pe_d    = rx_par_bad;
            end
        end
    end

    // RX registers; reset drops any partial frame and clears all flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_fe_q    <= 1'b0;
            rx_pe_q    <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_fe_q    <= rx_fe_d;
            rx_pe_q    <= rx_pe_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_frame_err  = rx_fe_q;
    assign rx_parity_err = rx_pe_q;
    assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: two uart_core instances (8N1 and 7E2, TICK_DIV=1) exercised
// with loopback, bench-driven RX frames, glitches, overrun and reset.
module tb_uart_core;
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = 16;
  localparam int W      = 10;  // {parity_err, frame_err, data[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A: 8N1 ----------------
  logic       a_tx_valid, a_tx_ready, a_tx, a_rx, a_rx_valid, a_rx_ready;
  logic [7:0] a_tx_data, a_rx_data;
  logic       a_fe, a_pe, a_ovr, a_loop, a_rx_drv;
  assign a_rx = a_loop ? a_tx : a_rx_drv;

  uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready), .tx(a_tx),
    .rx(a_rx), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_data(a_rx_data),
    .rx_frame_err(a_fe), .rx_parity_err(a_pe), .rx_overrun(a_ovr)
  );

  // ---------------- instance B: 7E2 ----------------
  logic       b_tx_valid, b_tx_ready, b_tx, b_rx, b_rx_valid, b_rx_ready;
  logic [6:0] b_tx_data, b_rx_data;
  logic       b_fe, b_pe, b_ovr, b_loop, b_rx_drv;
  assign b_rx = b_loop ? b_tx : b_rx_drv;

  uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .reset(reset),
    .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready), .tx(b_tx),
    .rx(b_rx), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_data(b_rx_data),
    .rx_frame_err(b_fe), .rx_parity_err(b_pe), .rx_overrun(b_ovr)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic exp_ovr_a = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame builder: line bits LSB first from the frame rules.
  function automatic int build_frame(input logic [7:0] d, input int dbits, input int par,
                                     input int stops, input bit flip_par, input bit low_stop,
                                     output logic [15:0] bits);
    int n;
    int ones;
    logic pbit;
    bits = '1;
    n = 0;
    ones = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < dbits; i++) begin
      bits[n] = d[i];
      if (d[i]) ones++;
      n++;
    end
    if (par != 0) begin
      // odd: total ones incl. parity bit odd; even: total even
      pbit = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      bits[n] = pbit ^ flip_par; n++;
    end
    for (int s = 0; s < stops; s++) begin
      bits[n] = (low_stop && s == 0) ? 1'b0 : 1'b1;
      n++;
    end
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_tx(input bit wb, input logic [7:0] d, input string tag);
    logic [15:0] bits;
    int n;
    int cnt;
    n = build_frame(d, wb ? 7 : 8, wb ? 2 : 0, wb ? 2 : 1, 1'b0, 1'b0, bits);
    cnt = 0;
    @(negedge clk);
    while (!(wb ? b_tx_ready : a_tx_ready) && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 400) begin
      check_eq({tag, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (wb) begin b_tx_valid = 1'b1; b_tx_data = d[6:0]; end
    else    begin a_tx_valid = 1'b1; a_tx_data = d; end
    @(posedge clk); #1;
    a_tx_valid = 1'b0;
    b_tx_valid = 1'b0;
    a_tx_data  = 8'($urandom);
    b_tx_data  = 7'($urandom);
    for (int k = 0; k <= n * BIT; k++) begin
      @(negedge clk);
      if (k % BIT == BIT / 2)
        check_eq($sformatf("%s_bit%0d", tag, k / BIT), 32'(wb ? b_tx : a_tx), 32'(bits[k / BIT]));
      if (k == 0 || k == n * BIT - 1)
        check_eq($sformatf("%s_busy%0d", tag, k), 32'(wb ? b_tx_ready : a_tx_ready), 32'd0);
      if (k == n * BIT)
        check_eq({tag, "_ready_end"}, 32'(wb ? b_tx_ready : a_tx_ready), 32'd1);
    end
  endtask

  task automatic drive_rx(input bit wb, input logic [15:0] bits, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (wb) b_rx_drv = bits[i];
      else    a_rx_drv = bits[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    a_rx_drv = 1'b1;
    b_rx_drv = 1'b1;
    repeat (2 * BIT) @(posedge clk);
  endtask

  task automatic recv_check(input bit wb, input string tag);
    int cnt;
    logic [W-1:0] e;
    int qs;
    cnt = 0;
    @(negedge clk);
    while (!(wb ? b_rx_valid : a_rx_valid) && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 600) begin
      check_eq({tag, "_valid_timeout"}, 32'd0, 32'd1);
      return;
    end
    qs = wb ? exp_b_q.size() : exp_a_q.size();
    check_eq({tag, "_exp_avail"}, 32'(qs > 0), 32'd1);
    if (qs == 0) return;
    e = wb ? exp_b_q.pop_front() : exp_a_q.pop_front();
    check_eq({tag, "_data"}, wb ? 32'(b_rx_data) : 32'(a_rx_data), 32'(e[7:0]));
    check_eq({tag, "_fe"}, 32'(wb ? b_fe : a_fe), 32'(e[8]));
    check_eq({tag, "_pe"}, 32'(wb ? b_pe : a_pe), 32'(e[9]));
    check_eq({tag, "_ovr"}, 32'(wb ? b_ovr : a_ovr), wb ? 32'd0 : 32'(exp_ovr_a));
    if (wb) b_rx_ready = 1'b1; else a_rx_ready = 1'b1;
    @(negedge clk);
    a_rx_ready = 1'b0;
    b_rx_ready = 1'b0;
    check_eq({tag, "_ack"}, 32'(wb ? b_rx_valid : a_rx_valid), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] bits;
    logic [7:0]  d;
    int n;
    bit flip, low, seen;

    a_tx_valid = 1'b0; a_tx_data = '0; a_rx_ready = 1'b0; a_loop = 1'b0; a_rx_drv = 1'b1;
    b_tx_valid = 1'b0; b_tx_data = '0; b_rx_ready = 1'b0; b_loop = 1'b0; b_rx_drv = 1'b1;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst_a_tx", 32'(a_tx), 32'd1);
    check_eq("rst_a_ready", 32'(a_tx_ready), 32'd1);
    check_eq("rst_a_valid", 32'(a_rx_valid), 32'd0);
    check_eq("rst_a_data", 32'(a_rx_data), 32'd0);
    check_eq("rst_a_fe", 32'(a_fe), 32'd0);
    check_eq("rst_a_pe", 32'(a_pe), 32'd0);
    check_eq("rst_a_ovr", 32'(a_ovr), 32'd0);
    check_eq("rst_b_tx", 32'(b_tx), 32'd1);
    check_eq("rst_b_ready", 32'(b_tx_ready), 32'd1);
    reset = 1'b0;

    // 8N1 loopback: 0xA5 first, then random bytes
    a_loop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = (i == 0) ? 8'hA5 : 8'($urandom);
      exp_a_q.push_back({2'b00, d});
      send_tx(1'b0, d, "a_tx");
      recv_check(1'b0, "a_loop");
    end
    a_loop = 1'b0;

    // 7E2 loopback: 0x35 first, then random 7-bit values
    b_loop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? 8'h35 : 8'($urandom_range(0, 127));
      exp_b_q.push_back({2'b00, d});
      send_tx(1'b1, d, "b_tx");
      recv_check(1'b1, "b_loop");
    end
    b_loop = 1'b0;

    // 7E2 parity bit forced wrong, then random frames with random parity faults
    n = build_frame(8'h35, 7, 2, 2, 1'b1, 1'b0, bits);
    exp_b_q.push_back({2'b10, 8'h35});
    drive_rx(1'b1, bits, n);
    recv_check(1'b1, "b_par_err");
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 127));
      flip = 1'($urandom_range(0, 1));
      n = build_frame(d, 7, 2, 2, flip, 1'b0, bits);
      exp_b_q.push_back({flip, 1'b0, d});
      drive_rx(1'b1, bits, n);
      recv_check(1'b1, "b_rand_rx");
    end

    // 8N1 framing error on 0x3C, then random frames with random stop faults
    n = build_frame(8'h3C, 8, 0, 1, 1'b0, 1'b1, bits);
    exp_a_q.push_back({2'b01, 8'h3C});
    drive_rx(1'b0, bits, n);
    recv_check(1'b0, "a_frame_err");
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      low = 1'($urandom_range(0, 1));
      n = build_frame(d, 8, 0, 1, 1'b0, low, bits);
      exp_a_q.push_back({1'b0, low, d});
      drive_rx(1'b0, bits, n);
      recv_check(1'b0, "a_rand_rx");
    end

    // 5-clock glitch must not produce a frame; a real frame follows
    @(posedge clk); #1;
    a_rx_drv = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    a_rx_drv = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen |= a_rx_valid;
    end
    check_eq("glitch_no_valid", 32'(seen), 32'd0);
    n = build_frame(8'h81, 8, 0, 1, 1'b0, 1'b0, bits);
    exp_a_q.push_back({2'b00, 8'h81});
    drive_rx(1'b0, bits, n);
    recv_check(1'b0, "a_after_glitch");

    // Overrun: 0x11 held, 0x22 dropped
    n = build_frame(8'h11, 8, 0, 1, 1'b0, 1'b0, bits);
    exp_a_q.push_back({2'b00, 8'h11});
    drive_rx(1'b0, bits, n);
    @(negedge clk);
    check_eq("ovr_first_valid", 32'(a_rx_valid), 32'd1);
    check_eq("ovr_first_flag", 32'(a_ovr), 32'd0);
    n = build_frame(8'h22, 8, 0, 1, 1'b0, 1'b0, bits);
    drive_rx(1'b0, bits, n);
    @(negedge clk);
    check_eq("ovr_data_kept", 32'(a_rx_data), 32'h11);
    check_eq("ovr_flag", 32'(a_ovr), 32'd1);
    exp_ovr_a = 1'b1;
    recv_check(1'b0, "a_ovr");
    repeat (10) @(negedge clk);
    check_eq("ovr_sticky", 32'(a_ovr), 32'd1);
    n = build_frame(8'h5E, 8, 0, 1, 1'b0, 1'b0, bits);
    exp_a_q.push_back({2'b00, 8'h5E});
    drive_rx(1'b0, bits, n);
    recv_check(1'b0, "a_after_ovr");

    // Reset during TX data bits
    @(negedge clk);
    a_tx_valid = 1'b1;
    a_tx_data  = 8'h5A;
    @(posedge clk); #1;
    a_tx_valid = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    check_eq("midtx_busy", 32'(a_tx_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("midtx_rst_tx", 32'(a_tx), 32'd1);
    check_eq("midtx_rst_ready", 32'(a_tx_ready), 32'd1);
    check_eq("midtx_rst_ovr", 32'(a_ovr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_ovr_a = 1'b0;
    a_loop = 1'b1;
    d = 8'($urandom);
    exp_a_q.push_back({2'b00, d});
    send_tx(1'b0, d, "a_tx_post_rst");
    recv_check(1'b0, "a_post_rst");
    a_loop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
